// File: rtl/eth_stream_arbiter.sv
// eth_stream_arbiter
//   Round-robin arbiter for the per-channel AXI-to-stream submodules. It grants the
//   shared Ethernet TX stream to one requester at a time, holds that grant until the
//   packet's final beat, and muxes the granted requester onto one AXI-Stream master.
//   Optional feature macro: ARB_WATCHDOG_EN (stall watchdog that forces grant release).
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   req_valid          per-requester beat available
//   req_in_progress    per-requester mid-packet flag, low on the final beat
//   req_data           packed per-requester data, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready          per-requester ready, at most one bit set
//   m_tdata/m_tvalid/m_tlast/m_tid, m_tready   AXI-Stream master towards Ethernet TX
//   pkt_count          completed packet counter, wraps at 16 bits
//   wd_error           sticky watchdog flag, constant 0 without ARB_WATCHDOG_EN
module eth_stream_arbiter #(
  parameter int unsigned NUM_REQ    = 5,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_in_progress,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  output logic [$clog2(NUM_REQ)-1:0]    m_tid,
  input  logic                          m_tready,
  output logic [15:0]                   pkt_count,
  output logic                          wd_error
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("eth_stream_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [15:0]      pkt_count_q, pkt_count_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  g_valid, g_last, xfer;
  logic                  scan_hit;
  logic [IDW-1:0]        scan_idx;
  logic [IDW-1:0]        next_ptr;

  // Unpack the flat data bus so the granted slice is a plain array lookup.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign g_valid  = req_valid[grant_q];
  assign g_last   = g_valid & ~req_in_progress[grant_q];
  assign xfer     = (state_q == BUSY) & g_valid & m_tready;
  // Requester after the current grant starts the next scan, so the finisher is last.
  assign next_ptr = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

  // Round-robin scan: first set req_valid bit at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned pos;
    scan_hit = 1'b0;
    scan_idx = '0;
    pos      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!scan_hit && req_valid[IDW'(pos)]) begin
        scan_hit = 1'b1;
        scan_idx = IDW'(pos);
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        wd_error_q, wd_error_d;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt_q   <= '0;
      wd_error_q <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      wd_error_q <= wd_error_d;
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_count_d = pkt_count_q;
`ifdef ARB_WATCHDOG_EN
    wd_cnt_d    = wd_cnt_q;
    wd_error_d  = wd_error_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (scan_hit) begin
          grant_d = scan_idx;
          state_d = BUSY;
`ifdef ARB_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
        end
      end
      BUSY: begin
        if (xfer) begin
`ifdef ARB_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
          if (g_last) begin
            pkt_count_d = pkt_count_q + 16'd1;
            rr_ptr_d    = next_ptr;
            state_d     = IDLE;
          end
        end
`ifdef ARB_WATCHDOG_EN
        // Stalled grant: release it once the counter would reach TIMEOUT.
        else if (wd_cnt_q == 32'(TIMEOUT - 1)) begin
          wd_cnt_d   = '0;
          wd_error_d = 1'b1;
          rr_ptr_d   = next_ptr;
          state_d    = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 32'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: combinational from the grant register, all zero outside BUSY.
  always_comb begin
    req_ready = '0;
    m_tdata   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tid     = '0;
    if (state_q == BUSY) begin
      req_ready[grant_q] = m_tready;
      m_tdata            = data_arr[grant_q];
      m_tvalid           = g_valid;
      m_tlast            = g_last;
      m_tid              = grant_q;
    end
  end

  assign pkt_count = pkt_count_q;
`ifdef ARB_WATCHDOG_EN
  assign wd_error = wd_error_q;
`else
  assign wd_error = 1'b0;
`endif

endmodule
